// File: rtl/ldst_mmio_bridge_if.sv
// rtl/ldst_mmio_bridge_if.sv - CPU load/store port and data-memory port bundle
interface ldst_mmio_bridge_if;
    logic [15:0] i_ldst_addr;
    logic        i_ldst_rd;
    logic        i_ldst_wr;
    logic [15:0] i_ldst_wrdata;
    logic [15:0] o_ldst_rddata;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic [15:0] o_mem_wrdata;
    logic [15:0] i_mem_rddata;

    modport slave (
        input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_mem_rddata,
        output o_ldst_rddata, o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata
    );

    modport master (
        output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_mem_rddata,
        input  o_ldst_rddata, o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata
    );
endinterface

// File: rtl/ldst_mmio_bridge.sv
// rtl/ldst_mmio_bridge.sv - load/store decoder with local timer and GPIO peripheral window
module ldst_mmio_bridge #(
    parameter logic [15:0] PERIPH_BASE = 16'hFF00,
    parameter int          GPIO_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    ldst_mmio_bridge_if.slave bus,
    input  logic [GPIO_W-1:0] i_gpio,
    output logic [GPIO_W-1:0] o_gpio,
    output logic              o_irq
);
    logic [2:0]        ctrl_q, ctrl_d;
    logic [15:0]       prescale_q, prescale_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       reload_q, reload_d;
    logic              expired_q, expired_d;
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [15:0]       pre_cnt_q, pre_cnt_d;
    logic [15:0]       rd_q, rd_d;
    logic              src_periph_q, rd_pend_q;
    logic [15:0]       rddata_q;

    logic        hit, wr_p, tick, count_wr, expire;
    logic [3:0]  off;

    assign hit      = (bus.i_ldst_addr[15:4] == PERIPH_BASE[15:4]);
    assign off      = bus.i_ldst_addr[3:0];
    assign wr_p     = bus.i_ldst_wr & hit;
    assign tick     = ctrl_q[0] && (pre_cnt_q == prescale_q);
    assign count_wr = wr_p && (off == 4'd2);
    // A CPU write to COUNT overrides everything the tick would have done.
    assign expire   = tick && (count_q == 16'd0) && !count_wr;

    assign bus.o_mem_addr   = bus.i_ldst_addr;
    assign bus.o_mem_rd     = bus.i_ldst_rd & ~hit;
    assign bus.o_mem_wr     = bus.i_ldst_wr & ~hit;
    assign bus.o_mem_wrdata = bus.i_ldst_wrdata;

    assign bus.o_ldst_rddata = rd_pend_q ? (src_periph_q ? rd_q : bus.i_mem_rddata) : rddata_q;
    assign o_gpio = gpio_out_q;
    assign o_irq  = expired_q & ctrl_q[2];

    always_comb begin
        rd_d = 16'd0;
        case (off)
            4'd0:    rd_d = {13'd0, ctrl_q};
            4'd1:    rd_d = prescale_q;
            4'd2:    rd_d = count_q;
            4'd3:    rd_d = reload_q;
            4'd4:    rd_d = {15'd0, expired_q};
            4'd5:    rd_d = 16'(gpio_out_q);
            4'd6:    rd_d = 16'(sync2_q);
            default: rd_d = 16'd0;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        reload_d   = reload_q;
        expired_d  = expired_q;
        gpio_out_d = gpio_out_q;
        pre_cnt_d  = 16'd0;

        if (ctrl_q[0] && !tick)
            pre_cnt_d = pre_cnt_q + 16'd1;

        if (tick && !count_wr) begin
            if (count_q != 16'd0)
                count_d = count_q - 16'd1;
            else if (ctrl_q[1])
                count_d = reload_q;
            else
                ctrl_d[0] = 1'b0;
        end

        if (wr_p) begin
            case (off)
                4'd0: ctrl_d     = bus.i_ldst_wrdata[2:0];
                4'd1: prescale_d = bus.i_ldst_wrdata;
                4'd2: count_d    = bus.i_ldst_wrdata;
                4'd3: reload_d   = bus.i_ldst_wrdata;
                4'd4: if (bus.i_ldst_wrdata[0]) expired_d = 1'b0;
                4'd5: gpio_out_d = bus.i_ldst_wrdata[GPIO_W-1:0];
                default: ;
            endcase
        end

        // Expiry beats a simultaneous STATUS clear.
        if (expire)
            expired_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q       <= '0;
            prescale_q   <= '0;
            count_q      <= '0;
            reload_q     <= '0;
            expired_q    <= 1'b0;
            gpio_out_q   <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            pre_cnt_q    <= '0;
            rd_q         <= '0;
            src_periph_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            rddata_q     <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            expired_q  <= expired_d;
            gpio_out_q <= gpio_out_d;
            sync1_q    <= i_gpio;
            sync2_q    <= sync1_q;
            pre_cnt_q  <= pre_cnt_d;
            rd_pend_q  <= bus.i_ldst_rd;
            rddata_q   <= bus.o_ldst_rddata;
            if (bus.i_ldst_rd) begin
                src_periph_q <= hit;
                if (hit)
                    rd_q <= rd_d;
            end
        end
    end
endmodule

// File: tb/tb_ldst_mmio_bridge.sv
// tb/tb_ldst_mmio_bridge.sv - vector table, directed timer sequences and randomized model check
module tb_ldst_mmio_bridge;
    localparam int GW = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [GW-1:0] i_gpio, o_gpio;
    logic o_irq;

    always #5 clk = ~clk;

    ldst_mmio_bridge_if bus();

    ldst_mmio_bridge #(.PERIPH_BASE(16'hFF00), .GPIO_W(GW)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .i_gpio(i_gpio), .o_gpio(o_gpio), .o_irq(o_irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]  m_ctrl;
    logic [15:0] m_pre, m_count, m_reload, m_gpo, m_s1, m_s2, m_pcnt, m_out;
    logic        m_exp;
    logic        last_mrd, last_mwr;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] memval;
        logic [15:0] exp_rd;
        logic        exp_mrd;
        logic        exp_mwr;
        logic [15:0] exp_gpio;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_pre = 0; m_count = 0; m_reload = 0; m_gpo = 0;
        m_s1 = 0; m_s2 = 0; m_pcnt = 0; m_out = 0; m_exp = 0;
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] off);
        logic [15:0] regs [0:15];
        for (int i = 0; i < 16; i++) regs[i] = 16'd0;
        regs[0] = {13'd0, m_ctrl};
        regs[1] = m_pre;
        regs[2] = m_count;
        regs[3] = m_reload;
        regs[4] = {15'd0, m_exp};
        regs[5] = m_gpo;
        regs[6] = m_s2;
        return regs[off];
    endfunction

    // One bus cycle: drive, check the pass-through, clock, then check against the model.
    task automatic step(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] memval, input logic [GW-1:0] gpio);
        logic hit, tick, cw, setx;
        logic [3:0] off;
        logic [2:0] n_ctrl;
        logic [15:0] n_count, n_pre, n_reload, n_gpo, n_pcnt, n_out;
        logic n_exp;
        bus.i_ldst_rd = rd; bus.i_ldst_wr = wr; bus.i_ldst_addr = addr;
        bus.i_ldst_wrdata = wdata; i_gpio = gpio;
        #1;
        hit = (addr[15:4] == 12'hFF0);
        off = addr[3:0];
        chk("mem_rd", bus.o_mem_rd, rd & !hit);
        chk("mem_wr", bus.o_mem_wr, wr & !hit);
        chk("mem_addr", bus.o_mem_addr, addr);
        chk("mem_wrdata", bus.o_mem_wrdata, wdata);
        last_mrd = bus.o_mem_rd;
        last_mwr = bus.o_mem_wr;

        tick = m_ctrl[0] && (m_pcnt == m_pre);
        n_pcnt = (m_ctrl[0] && !tick) ? m_pcnt + 16'd1 : 16'd0;
        cw = wr && hit && off == 4'd2;
        n_ctrl = m_ctrl; n_count = m_count; n_pre = m_pre; n_reload = m_reload;
        n_gpo = m_gpo; n_exp = m_exp; setx = 1'b0;
        if (tick && !cw) begin
            if (m_count != 0) n_count = m_count - 16'd1;
            else begin
                setx = 1'b1;
                if (m_ctrl[1]) n_count = m_reload; else n_ctrl[0] = 1'b0;
            end
        end
        if (wr && hit) begin
            if (off == 0) n_ctrl = wdata[2:0];
            if (off == 1) n_pre = wdata;
            if (off == 2) n_count = wdata;
            if (off == 3) n_reload = wdata;
            if (off == 4 && wdata[0]) n_exp = 1'b0;
            if (off == 5) n_gpo = wdata;
        end
        if (setx) n_exp = 1'b1;
        n_out = m_out;
        if (rd) n_out = hit ? m_read(off) : memval;

        @(posedge clk);
        #1;
        bus.i_mem_rddata = memval;
        m_s2 = m_s1; m_s1 = gpio;
        m_ctrl = n_ctrl; m_count = n_count; m_pre = n_pre; m_reload = n_reload;
        m_gpo = n_gpo; m_exp = n_exp; m_pcnt = n_pcnt; m_out = n_out;
        #1;
        chk("rddata", bus.o_ldst_rddata, m_out);
        chk("gpio_out", o_gpio, m_gpo);
        chk("irq", o_irq, m_exp & m_ctrl[2]);
        bus.i_ldst_rd = 1'b0; bus.i_ldst_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0000, 16'h0000, 16'h0000, i_gpio);
    endtask

    initial begin
        int n;
        bus.i_ldst_rd = 0; bus.i_ldst_wr = 0; bus.i_ldst_addr = 0;
        bus.i_ldst_wrdata = 0; bus.i_mem_rddata = 0; i_gpio = 0;
        model_reset();

        tbl.push_back('{1, 0, 16'h1234, 16'h0000, 16'hBEEF, 16'hBEEF, 1, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h0010, 16'h1111, 16'h0000, 16'hBEEF, 0, 1, 16'h0000});
        tbl.push_back('{0, 1, 16'hFF05, 16'hA5A5, 16'h0000, 16'hBEEF, 0, 0, 16'hA5A5});
        tbl.push_back('{1, 0, 16'hFF05, 16'h0000, 16'h7777, 16'hA5A5, 0, 0, 16'hA5A5});
        tbl.push_back('{1, 0, 16'hFF09, 16'h0000, 16'h7777, 16'h0000, 0, 0, 16'hA5A5});
        tbl.push_back('{0, 1, 16'hFF01, 16'h1234, 16'h0000, 16'h0000, 0, 0, 16'hA5A5});
        tbl.push_back('{1, 0, 16'hFF01, 16'h0000, 16'h0000, 16'h1234, 0, 0, 16'hA5A5});
        tbl.push_back('{1, 1, 16'hFF03, 16'h5555, 16'h0000, 16'h0000, 0, 0, 16'hA5A5});
        tbl.push_back('{1, 0, 16'hFF03, 16'h0000, 16'h0000, 16'h5555, 0, 0, 16'hA5A5});
        tbl.push_back('{1, 1, 16'h2000, 16'hCAFE, 16'h4321, 16'h4321, 1, 1, 16'hA5A5});
        tbl.push_back('{1, 0, 16'hFF06, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'hA5A5});
        tbl.push_back('{0, 1, 16'hFF09, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 16'hA5A5});
        tbl.push_back('{1, 0, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'hA5A5});
        tbl.push_back('{0, 1, 16'hFF05, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000});

        repeat (2) @(posedge clk);
        #2;
        chk("reset_rddata", bus.o_ldst_rddata, 16'h0000);
        chk("reset_gpio", o_gpio, 16'h0000);
        chk("reset_irq", o_irq, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].memval, 16'h0000);
            chk($sformatf("tbl%0d_rddata", i), bus.o_ldst_rddata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_mem_rd", i), last_mrd, tbl[i].exp_mrd);
            chk($sformatf("tbl%0d_mem_wr", i), last_mwr, tbl[i].exp_mwr);
            chk($sformatf("tbl%0d_gpio", i), o_gpio, tbl[i].exp_gpio);
        end

        // One-shot: 4 ticks of 3 cycles each before expiry
        step(0, 1, 16'hFF01, 16'd2, 0, 0);
        step(0, 1, 16'hFF02, 16'd3, 0, 0);
        step(0, 1, 16'hFF00, 16'h0005, 0, 0);
        n = 0;
        while (!o_irq && n < 40) begin
            idle(1);
            n++;
        end
        chk("oneshot_cycles", 16'(n), 16'd12);
        step(1, 0, 16'hFF00, 0, 0, 0);
        chk("oneshot_ctrl_en_clear", bus.o_ldst_rddata, 16'h0004);
        step(0, 1, 16'hFF04, 16'h0001, 0, 0);
        chk("oneshot_irq_cleared", o_irq, 1'b0);

        // Auto-reload every cycle, plus collisions
        step(0, 1, 16'hFF01, 16'd0, 0, 0);
        step(0, 1, 16'hFF03, 16'd1, 0, 0);
        step(0, 1, 16'hFF02, 16'd1, 0, 0);
        step(0, 1, 16'hFF00, 16'h0003, 0, 0);
        step(1, 0, 16'hFF02, 0, 0, 0);
        chk("auto_c1", bus.o_ldst_rddata, 16'd1);
        step(1, 0, 16'hFF02, 0, 0, 0);
        chk("auto_c2", bus.o_ldst_rddata, 16'd0);
        step(1, 0, 16'hFF02, 0, 0, 0);
        chk("auto_c3", bus.o_ldst_rddata, 16'd1);
        step(0, 1, 16'hFF04, 16'h0001, 0, 0);
        step(1, 0, 16'hFF04, 0, 0, 0);
        chk("clear_vs_expire", bus.o_ldst_rddata, 16'd1);
        idle(1);
        step(0, 1, 16'hFF04, 16'h0001, 0, 0);
        step(1, 0, 16'hFF04, 0, 0, 0);
        chk("clear_plain", bus.o_ldst_rddata, 16'd0);
        step(0, 1, 16'hFF02, 16'd7, 0, 0);
        step(1, 0, 16'hFF02, 0, 0, 0);
        chk("count_write_wins", bus.o_ldst_rddata, 16'd7);
        step(1, 0, 16'hFF00, 0, 0, 0);
        chk("auto_en_stays", bus.o_ldst_rddata, 16'h0003);
        step(0, 1, 16'hFF00, 16'h0000, 0, 0);

        // Async reset mid-count with a peripheral read outstanding
        step(0, 1, 16'hFF01, 16'd3, 0, 0);
        step(0, 1, 16'hFF02, 16'd5, 0, 0);
        step(0, 1, 16'hFF05, 16'h00FF, 0, 0);
        step(0, 1, 16'hFF00, 16'h0005, 0, 0);
        idle(3);
        step(1, 0, 16'hFF05, 0, 0, 0);
        chk("pre_reset_rd", bus.o_ldst_rddata, 16'h00FF);
        reset = 1'b0;
        #1;
        chk("async_rddata", bus.o_ldst_rddata, 16'h0000);
        chk("async_gpio", o_gpio, 16'h0000);
        chk("async_irq", o_irq, 1'b0);
        model_reset();
        i_gpio = 16'h0F00;
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        step(1, 0, 16'hFF06, 0, 0, 16'h0F00);
        chk("gpio_in_sync", bus.o_ldst_rddata, 16'h0F00);
        step(1, 0, 16'hFF02, 0, 0, 16'h0F00);
        chk("post_reset_count", bus.o_ldst_rddata, 16'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a, d;
            a = ($urandom_range(3) != 0) ? {12'hFF0, 4'($urandom_range(15))} : 16'($urandom);
            d = ($urandom_range(1) != 0) ? 16'($urandom_range(7)) : 16'($urandom);
            step(1'($urandom_range(1)), ($urandom_range(2) == 0), a, d, 16'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ldst_mmio_bridge.md
# ldst_mmio_bridge

Address decoder and peripheral block sitting directly downstream of the CPU's load/store port. It forwards RAM accesses to data memory unchanged and serves a small memory-mapped peripheral window locally: a prescaled down-counter timer with interrupt, a GPIO output register and a synchronised GPIO input. Read data returns to the CPU one cycle after the read strobe, matching synchronous RAM latency.

## Interface
- PERIPH_BASE, 16'hFF00, base of the 16-word peripheral window; decode is addr[15:4] == PERIPH_BASE[15:4]
- GPIO_W, 16, width of the GPIO in/out ports (1..16)

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low
- i_ldst_addr  in  16  CPU load/store address
- i_ldst_rd  in  1  CPU read strobe
- i_ldst_wr  in  1  CPU write strobe
- i_ldst_wrdata  in  16  CPU write data
- o_ldst_rddata  out  16  read data to CPU, valid the cycle after i_ldst_rd
- o_mem_addr  out  16  RAM address (= i_ldst_addr)
- o_mem_rd  out  1  i_ldst_rd & ~hit
- o_mem_wr  out  1  i_ldst_wr & ~hit
- o_mem_wrdata  out  16  = i_ldst_wrdata
- i_mem_rddata  in  16  RAM read data, one-cycle latency
- i_gpio  in  GPIO_W  asynchronous input pins
- o_gpio  out  GPIO_W  GPIO output register
- o_irq  out  1  expired & CTRL.irq_en

## Operation
- hit = addr[15:4] matches PERIPH_BASE[15:4]; offset = addr[3:0]
- Register map (offset: name):
  - 0 CTRL RW: bit0 en, bit1 auto_reload, bit2 irq_en; other bits read 0
  - 1 PRESCALE RW 16-bit
  - 2 COUNT RW; write loads counter
  - 3 RELOAD RW 16-bit
  - 4 STATUS: bit0 expired (sticky); write 1 to bit0 clears, write 0 no effect
  - 5 GPIO_OUT RW (low GPIO_W bits; upper bits read 0)
  - 6 GPIO_IN RO: two-flop synchronised i_gpio, zero-extended
  - 7..15 read 0, writes ignored
- Prescaler pre_cnt: held at 0 while en=0; while en=1, tick when pre_cnt == PRESCALE, then pre_cnt<=0, else pre_cnt+1. PRESCALE=0 ticks every cycle.
- On tick: COUNT != 0 -> COUNT-1. COUNT == 0 -> expired<=1; if auto_reload COUNT<=RELOAD, else en<=0.
- Read path: on i_ldst_rd at cycle N, latch src_periph=hit and, if hit, the addressed register's pre-write value into rd_q. At N+1: o_ldst_rddata = src_periph ? rd_q : i_mem_rddata. With no read at N, o_ldst_rddata holds last value returned.
- Simultaneous rd+wr to same peripheral address: write performed; read returns old value. To RAM: both strobes forwarded.

## Timing
- Reset (reset=0, async): CTRL, PRESCALE, COUNT, RELOAD, expired, GPIO_OUT, sync flops, pre_cnt, rd_q, src_periph all 0; o_ldst_rddata=0, o_gpio=0, o_irq=0. o_mem_* remain combinational pass-through of inputs.
- Register writes take effect the edge of the write cycle; visible on read next cycle.
- Write to COUNT in same cycle as tick: write wins, no decrement, no expire that cycle.
- Write to CTRL with en=0 in tick cycle: write wins.
- STATUS clear and expiry in same cycle: set wins (expired stays 1).
- o_irq is registered-state derived: rises the cycle after the expiring tick edge.
- GPIO_IN reflects i_gpio after 2 clock edges.
- Reset asserted mid-count or mid-read: all state cleared immediately; read in flight returns 0.

## Test plan
- RAM pass-through: rd addr 0x1234, i_mem_rddata=0xBEEF next cycle -> o_mem_rd=1, o_ldst_rddata=0xBEEF at N+1; wr to 0x0010 -> o_mem_wr=1, no peripheral change.
- Peripheral RW: write 0xA5A5 to 0xFF05 -> o_gpio=0xA5A5, o_mem_wr=0; read 0xFF05 -> 0xA5A5 at N+1; read 0xFF09 -> 0x0000.
- One-shot timer: PRESCALE=2, COUNT=3, CTRL=0x5 -> expired set after 12 cycles (4 ticks x 3), en self-clears, o_irq=1 next cycle; write 1 to STATUS -> o_irq=0.
- Auto-reload: PRESCALE=0, RELOAD=1, COUNT=1, CTRL=0x3 -> expiry every 2 cycles, COUNT cycles 1,0,1,0; en stays 1.
- Collisions: write COUNT=7 on tick cycle -> COUNT reads 7; STATUS clear coincident with expiry -> STATUS reads 1.
- Async reset mid-count (COUNT=5, en=1) -> all registers 0, o_irq=0, o_gpio=0 without clock edge; i_gpio=0x0F00 reads back after 2 cycles post-reset.
